// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, instruction field positions, fetch FSM states.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int RS_HI     = 25;
  localparam int RS_LO     = 21;
  localparam int RT_HI     = 20;
  localparam int RT_LO     = 16;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 11;
  localparam int SHAMT_HI  = 10;
  localparam int SHAMT_LO  = 6;
  localparam int FN_HI     = 5;
  localparam int FN_LO     = 0;
  localparam int IMM_HI    = 15;
  localparam int IMM_LO    = 0;
  localparam int TARGET_HI = 25;
  localparam int TARGET_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HOLD
  } fetch_state_e;

  function automatic logic [31:0] sign_extend16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/fetch_unit_next_pc.sv
// Next-PC selection: jump beats taken branch beats sequential; purely combinational.
// All arithmetic is 32-bit and wraps.
module next_pc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] target,
  input  logic [31:0] imm_sext,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] pc_plus4,
  output logic [31:0] pc_next
);

  always_comb begin
    pc_plus4 = pc + 32'd4;
    pc_next  = pc_plus4;
    if (jump) begin
      pc_next = {pc_plus4[31:28], target, 2'b00};
    end else if (branch && zero) begin
      pc_next = pc_plus4 + {imm_sext[29:0], 2'b00};
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, imem ready handshake, IF/ID register; >= 2 cycles per instruction.
// Stalls indefinitely in FETCH without imem_ready and in HOLD without instr_ack.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ack,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  output logic [5:0]  opCode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  fn,
  output logic [31:0] imm_sext,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

  fetch_state_e state, state_nxt;
  logic [31:0]  ifid;
  logic [31:0]  pc_next;
  logic         load_ifid;
  logic         advance;

  always_comb begin
    state_nxt = state;
    load_ifid = 1'b0;
    advance   = 1'b0;
    case (state)
      ST_IDLE:  state_nxt = ST_FETCH;
      ST_FETCH: if (imem_ready) begin
        load_ifid = 1'b1;
        state_nxt = ST_HOLD;
      end
      ST_HOLD:  if (instr_ack) begin
        advance   = 1'b1;
        state_nxt = ST_FETCH;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc          <= PC_INIT;
      ifid        <= '0;
      fetch_count <= '0;
    end else begin
      state <= state_nxt;
      if (load_ifid) begin
        ifid <= imem_rdata;
      end
      if (advance) begin
        pc          <= pc_next;
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

  // Outputs decode straight from state so they drop with an asynchronous reset.
  assign imem_req    = (state == ST_FETCH);
  assign instr_valid = (state == ST_HOLD);
  assign imem_addr   = pc;

  assign opCode   = ifid[OPCODE_HI:OPCODE_LO];
  assign rs       = ifid[RS_HI:RS_LO];
  assign rt       = ifid[RT_HI:RT_LO];
  assign rd       = ifid[RD_HI:RD_LO];
  assign shamt    = ifid[SHAMT_HI:SHAMT_LO];
  assign fn       = ifid[FN_HI:FN_LO];
  assign imm_sext = sign_extend16(ifid[IMM_HI:IMM_LO]);

  next_pc u_next_pc (
    .pc       (pc),
    .target   (ifid[TARGET_HI:TARGET_LO]),
    .imm_sext (imm_sext),
    .branch   (branch),
    .jump     (jump),
    .zero     (zero),
    .pc_plus4 (pc_plus4),
    .pc_next  (pc_next)
  );

endmodule
